// File: rtl/uart_transmitter_if.sv
// rtl/uart_transmitter_if.sv - bus-side handshake and serial line bundle for uart_transmitter
interface uart_transmitter_if;
    logic       baud_tick;
    logic       tx_start;
    logic [7:0] din;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    modport master (
        output baud_tick, tx_start, din,
        input  tx, tx_busy, tx_done
    );

    modport slave (
        input  baud_tick, tx_start, din,
        output tx, tx_busy, tx_done
    );
endinterface

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - UART serialiser on a 16x baud tick; optional parity bit under UART_TX_PARITY_EN
module uart_transmitter #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
`ifdef UART_TX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic                clk,
    input  logic                reset_n,
    uart_transmitter_if.slave   bus
);

    localparam logic [4:0] TICK_LAST = 5'd15;
    localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
    localparam logic [2:0] BIT_LAST  = 3'(DBIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t     r_state, w_state_next;
    logic [4:0] r_s, w_s_next;
    logic [2:0] r_n, w_n_next;
    logic [7:0] r_shift, w_shift_next;
    logic       r_tx, w_tx_next;
    logic       r_done, w_done_next;

`ifdef UART_TX_PARITY_EN
    logic [7:0] r_din_lat, w_din_lat_next;
    logic       w_parity;

    // Parity comes from the byte captured at acceptance, not the draining shifter.
    assign w_parity = (^r_din_lat[DBIT-1:0]) ^ PARITY_ODD;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_s       <= 5'd0;
            r_n       <= 3'd0;
            r_shift   <= 8'd0;
            r_tx      <= 1'b1;
            r_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_din_lat <= 8'd0;
`endif
        end else begin
            r_state   <= w_state_next;
            r_s       <= w_s_next;
            r_n       <= w_n_next;
            r_shift   <= w_shift_next;
            r_tx      <= w_tx_next;
            r_done    <= w_done_next;
`ifdef UART_TX_PARITY_EN
            r_din_lat <= w_din_lat_next;
`endif
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_s_next       = r_s;
        w_n_next       = r_n;
        w_shift_next   = r_shift;
        w_tx_next      = r_tx;
        w_done_next    = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_din_lat_next = r_din_lat;
`endif
        case (r_state)
            IDLE: begin
                w_tx_next = 1'b1;
                // Acceptance ignores baud_tick; a coincident tick is not counted.
                if (bus.tx_start) begin
                    w_shift_next = bus.din;
                    w_s_next     = 5'd0;
                    w_state_next = START;
                    w_tx_next    = 1'b0;
`ifdef UART_TX_PARITY_EN
                    w_din_lat_next = bus.din;
`endif
                end
            end
            START: begin
                w_tx_next = 1'b0;
                if (bus.baud_tick) begin
                    if (r_s == TICK_LAST) begin
                        w_s_next     = 5'd0;
                        w_n_next     = 3'd0;
                        w_state_next = DATA;
                        w_tx_next    = r_shift[0];
                    end else begin
                        w_s_next = r_s + 5'd1;
                    end
                end
            end
            DATA: begin
                w_tx_next = r_shift[0];
                if (bus.baud_tick) begin
                    if (r_s == TICK_LAST) begin
                        w_s_next     = 5'd0;
                        w_shift_next = {1'b0, r_shift[7:1]};
                        if (r_n == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                            w_state_next = PARITY;
                            w_tx_next    = w_parity;
`else
                            w_state_next = STOP;
                            w_tx_next    = 1'b1;
`endif
                        end else begin
                            w_n_next  = r_n + 3'd1;
                            w_tx_next = r_shift[1];
                        end
                    end else begin
                        w_s_next = r_s + 5'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                w_tx_next = w_parity;
                if (bus.baud_tick) begin
                    if (r_s == TICK_LAST) begin
                        w_s_next     = 5'd0;
                        w_state_next = STOP;
                        w_tx_next    = 1'b1;
                    end else begin
                        w_s_next = r_s + 5'd1;
                    end
                end
            end
`endif
            STOP: begin
                w_tx_next = 1'b1;
                if (bus.baud_tick) begin
                    if (r_s == STOP_LAST) begin
                        w_s_next     = 5'd0;
                        w_state_next = IDLE;
                        w_done_next  = 1'b1;
                    end else begin
                        w_s_next = r_s + 5'd1;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
                w_tx_next    = 1'b1;
            end
        endcase
    end

    assign bus.tx      = r_tx;
    assign bus.tx_busy = (r_state != IDLE);
    assign bus.tx_done = r_done;

endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - directed self-checking bench for uart_transmitter (8N1, optional parity build)
module tb_uart_transmitter;

`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_fail;
    int   phase;

    uart_transmitter_if bus ();

    uart_transmitter #(.DBIT(8), .SB_TICK(16)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

`ifdef UART_TX_PARITY_EN
    uart_transmitter_if bus_odd ();
    assign bus_odd.baud_tick = bus.baud_tick;
    assign bus_odd.tx_start  = bus.tx_start;
    assign bus_odd.din       = bus.din;

    uart_transmitter #(.DBIT(8), .SB_TICK(16), .PARITY_ODD(1'b1)) u_dut_odd (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_odd.slave)
    );

    logic tx_alt;
    assign tx_alt = bus_odd.tx;
`else
    logic tx_alt;
    assign tx_alt = bus.tx;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: land on the falling edge, then set the baud strobe for the next rising edge.
    task automatic cycle();
        @(negedge clk);
        phase     = (phase + 1) % 4;
        bus.baud_tick = (phase == 0);
    endtask

    function automatic logic [NB-1:0] frame_bits(input logic [7:0] d);
        logic [NB-1:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = d;
`ifdef UART_TX_PARITY_EN
        f[9]   = ^d;
`endif
        return f;
    endfunction

    // Request a frame on an edge that also carries a baud tick; returns at the first falling edge after acceptance.
    task automatic start_frame(input logic [7:0] d);
        for (int k = 0; k < 4 && !bus.baud_tick; k++) cycle();
        bus.tx_start = 1'b1;
        bus.din      = d;
        cycle();
        bus.tx_start = 1'b0;
    endtask

    // Sample the line at each bit's first, middle and last clock; ofs is the boundary shift after the start bit.
    task automatic capture(input int ofs, input bit chain, input logic [7:0] next_din, input int inject_at,
                           output logic [NB-1:0] first_v, output logic [NB-1:0] mid_v, output logic [NB-1:0] last_v,
                           output logic [NB-1:0] mid_odd, output int done_c, output int done_n,
                           output logic busy0, output logic busy_done);
        first_v = '0; mid_v = '0; last_v = '0; mid_odd = '0;
        done_c = -1; done_n = 0; busy0 = 1'b0; busy_done = 1'b1;
        for (int c = 0; c < NB*64 + ofs + 4; c++) begin
            if (c != 0) begin
                cycle();
                bus.tx_start = 1'b0;
            end
            if (c == 0) busy0 = bus.tx_busy;
            for (int i = 0; i < NB; i++) begin
                if (c == ((i == 0) ? 0 : 64*i + ofs)) first_v[i] = bus.tx;
                if (c == 64*i + 32) begin
                    mid_v[i]   = bus.tx;
                    mid_odd[i] = tx_alt;
                end
                if (c == 64*i + 63 + ofs) last_v[i] = bus.tx;
            end
            if (bus.tx_done) begin
                done_n++;
                if (done_c < 0) begin
                    done_c    = c;
                    busy_done = bus.tx_busy;
                end
            end
            if (c == inject_at) begin
                bus.tx_start = 1'b1;
                bus.din      = 8'hFF;
            end
            if (chain && bus.tx_done) begin
                bus.tx_start = 1'b1;
                bus.din      = next_din;
                cycle();
                bus.tx_start = 1'b0;
                break;
            end
        end
    endtask

    task automatic run_and_check(input string tag, input logic [7:0] d, input int ofs, input bit chain,
                                 input logic [7:0] next_din, input int inject_at);
        logic [NB-1:0] fv, mv, lv, mo;
        int dc, dn;
        logic b0, bd;
        capture(ofs, chain, next_din, inject_at, fv, mv, lv, mo, dc, dn, b0, bd);
        check({tag, "_first"}, 32'(fv), 32'(frame_bits(d)));
        check({tag, "_mid"},   32'(mv), 32'(frame_bits(d)));
        check({tag, "_last"},  32'(lv), 32'(frame_bits(d)));
        check({tag, "_byte"},  32'(mv[8:1]), 32'(d));
        check({tag, "_done_at"}, 32'(dc), 32'(NB*64 + ofs));
        check({tag, "_done_cnt"}, 32'(dn), 32'd1);
        check({tag, "_busy0"}, 32'(b0), 32'd1);
        check({tag, "_busy_done"}, 32'(bd), 32'd0);
    endtask

    initial begin
        int lows, dones;
        n_checks = 0; n_fail = 0; phase = 0;
        reset_n = 1'b0;
        bus.baud_tick = 1'b0;
        bus.tx_start  = 1'b1;
        bus.din       = 8'h55;

        // Reset held with a pending request: line stays idle.
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("rst_tx", 32'(bus.tx), 32'd1);
            check("rst_busy", 32'(bus.tx_busy), 32'd0);
            check("rst_done", 32'(bus.tx_done), 32'd0);
        end
        for (int k = 0; k < 4 && !bus.baud_tick; k++) cycle();
        reset_n = 1'b1;
        check("rel_tx_before_edge", 32'(bus.tx), 32'd1);
        cycle();
        bus.tx_start = 1'b0;
        check("rel_accept_tx", 32'(bus.tx), 32'd0);
        run_and_check("f55", 8'h55, 0, 1'b0, 8'h00, -1);
`ifndef UART_TX_PARITY_EN
        check("f55_pattern", 32'(frame_bits(8'h55)), 32'h2AA);
`endif

        // Mid-frame request ignored; then three contiguous frames.
        repeat (10) cycle();
        start_frame(8'hA3);
        run_and_check("fA3", 8'hA3, 0, 1'b1, 8'h0F, 300);
        run_and_check("f0F", 8'h0F, -1, 1'b1, 8'hF0, -1);
        run_and_check("fF0", 8'hF0, -1, 1'b0, 8'h00, -1);

        // Asynchronous reset midway through data bit 3 of 0x00.
        repeat (10) cycle();
        start_frame(8'h00);
        for (int c = 1; c <= 64*4 + 32; c++) cycle();
        check("abort_tx_pre", 32'(bus.tx), 32'd0);
        check("abort_busy_pre", 32'(bus.tx_busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("abort_tx_async", 32'(bus.tx), 32'd1);
        check("abort_busy_async", 32'(bus.tx_busy), 32'd0);
        repeat (3) cycle();
        reset_n = 1'b1;
        lows = 0; dones = 0;
        for (int c = 0; c < 700; c++) begin
            cycle();
            if (bus.tx_done) dones++;
            if (!bus.tx) lows++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        check("abort_idle_line", 32'(lows), 32'd0);
        start_frame(8'h81);
        run_and_check("f81", 8'h81, 0, 1'b0, 8'h00, -1);

`ifdef UART_TX_PARITY_EN
        begin
            logic [NB-1:0] fv, mv, lv, mo;
            int dc, dn;
            logic b0, bd;
            repeat (10) cycle();
            start_frame(8'hA7);
            capture(0, 1'b0, 8'h00, -1, fv, mv, lv, mo, dc, dn, b0, bd);
            check("par_even_bit", 32'(mv[9]), 32'd1);
            check("par_odd_bit", 32'(mo[9]), 32'd0);
            check("par_done_at", 32'(dc), 32'd704);
            check("par_byte", 32'(mv[8:1]), 32'hA7);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
Serialises one byte per request onto a UART line: start bit, DBIT data bits LSB-first, then stop bit(s).
Timing comes from the shared 16x oversampling `baud_tick` strobe, the same one the UART receiver uses, so one bit period is 16 ticks.
Sits beside the receiver in the UART peripheral. The bus-side register logic drives `tx_start`/`din` and watches `tx_busy`/`tx_done`.

Parameters:
- DBIT, 8, number of data bits per frame (5..8).
- SB_TICK, 16, stop-bit length in baud_tick counts (16 = 1 stop bit, 24 = 1.5, 32 = 2).

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- baud_tick  input  1  one-clk-wide strobe at 16x baud rate.
- tx_start  input  1  request to send `din`; honoured only in IDLE.
- din  input  8  byte to send; bits [DBIT-1:0] are used.
- tx  output  1  serial line, registered, idle high.
- tx_busy  output  1  high whenever state != IDLE.
- tx_done  output  1  one-clk pulse at frame completion.

Behaviour:
- Reset values (async, reset_n low):
  - state = IDLE, tick counter s = 0, bit counter n = 0, shift register = 0.
  - tx = 1, tx_busy = 0, tx_done = 0.
- States: IDLE, START, DATA, STOP; PARITY is added only under the optional feature.
- tx is a flop loaded from the next-state value, so it changes on the same clk edge as the state.
- IDLE:
  - tx = 1.
  - On a clk edge with tx_start = 1: latch din into the shift register, clear s, enter START, tx becomes 0.
  - baud_tick is not required to accept a request; acceptance latency is 0 cycles, with tx low on the accepting edge.
- START:
  - tx = 0.
  - On each baud_tick: if s == 15, set s = 0, n = 0 and go to DATA (tx = shift[0]); else s = s + 1.
  - Cycles without a tick hold all state.
- DATA:
  - tx = shift[0].
  - On a baud_tick with s == 15: set s = 0 and shift right by one. If n == DBIT-1, go to STOP (tx = 1); else n = n + 1 and tx takes the new shift[0].
  - On any other tick: s = s + 1.
- STOP:
  - tx = 1.
  - On a baud_tick with s == SB_TICK-1: go to IDLE and assert tx_done for exactly one clk, on the same edge.
  - Otherwise s = s + 1 on each tick.
- Frame length (8N1, SB_TICK = 16): 16 + 128 + 16 = 160 baud_ticks from tx falling to tx_done.
- tx_start is ignored while tx_busy = 1. din is never re-sampled mid-frame, so changing din during a frame has no effect.
- Back-to-back frames:
  - tx_start high in the cycle tx_done is high is accepted, because state is already IDLE.
  - The next start bit begins on that edge, so there is no extra idle bit.
- baud_tick and tx_start high together in IDLE: the request is accepted, and that tick is not counted.
- reset_n asserted mid-frame: tx returns to 1 immediately (asynchronous), no tx_done, and the frame is abandoned.
- Counter widths:
  - s is 5 bits, to cover SB_TICK up to 32.
  - n is 3 bits.
  - No wrap beyond the terminal compare is reachable.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- When defined:
  - Parameter PARITY_ODD (default 0) is added.
  - A PARITY state sits between DATA and STOP, lasting 16 baud_ticks.
  - tx = ^din_latched[DBIT-1:0] XOR PARITY_ODD. The parity is computed from the byte latched at acceptance, not from the shifted register.
  - Frame length for 8E1 is 176 ticks.
- When undefined: the PARITY state, the PARITY_ODD parameter and the parity logic do not exist, and DATA goes directly to STOP.

Test Plan:
1. Reset with tx_start = 1 held: tx = 1, tx_busy = 0, tx_done = 0 throughout reset. No frame starts until reset_n rises and the next edge sees tx_start = 1.
2. baud_tick every 4 clk, send 0x55 (8N1):
   - Each bit lasts exactly 64 clk.
   - Line sequence is 0,1,0,1,0,1,0,1,0,1 (start, data LSB-first, stop).
   - tx_done is a single pulse 640 clk after tx falls.
   - Bench receiver (the team's uart_receiver on loopback) reports 0x55.
3. Send 0xA3, then pulse tx_start with din = 0xFF mid-frame: the second request is ignored. Line carries only 0xA3 bits (1,1,0,0,0,1,0,1) and exactly one tx_done pulse.
4. Back-to-back: assert tx_start with 0x0F in the tx_done cycle, then 0xF0. The two frames are contiguous with no idle gap, and loopback receives 0x0F then 0xF0.
5. Assert reset_n low halfway through data bit 3 of 0x00: tx goes to 1 asynchronously, no tx_done. A subsequent send of 0x81 completes correctly.
6. UART_TX_PARITY_EN with PARITY_ODD = 0, send 0xA7 (five 1s): parity bit = 1, tx_done after 176 ticks. With PARITY_ODD = 1: parity bit = 0.
